// File: rtl/pulse_burst_arbiter.sv
// Two-requester round-robin arbiter driving a shared pulse train of HIGH_W/LOW_W phases.
// Optional feature macro PULSE_ABORT_EN adds an abort input that ends a running burst early.
module pulse_burst_arbiter #(
   parameter int unsigned HIGH_W = 3,
   parameter int unsigned LOW_W  = 3
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       req0,
   input  logic [2:0] len0,
   input  logic       req1,
   input  logic [2:0] len1,
`ifdef PULSE_ABORT_EN
   input  logic       abort,
`endif
   output logic       gnt0,
   output logic       gnt1,
   output logic       signal,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_W - 1);
   localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      HIGH,
      LOW,
      DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] phase_cnt;
   logic [CNT_W-1:0] pulse_cnt;
   logic             last_srv;
   logic             pick0_c;

   // A len of 0 stands for a full burst of 8 pulses.
   function automatic logic [CNT_W-1:0] pulses_of(input logic [2:0] len);
      return (len == 3'd0) ? CNT_W'(8) : CNT_W'(len);
   endfunction

   // Requester 0 wins when alone or when requester 1 was served last.
   assign pick0_c = req0 & (~req1 | last_srv);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         phase_cnt <= '0;
         pulse_cnt <= '0;
         last_srv  <= 1'b1;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         signal    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  state <= GRANT;
                  busy  <= 1'b1;
                  if (pick0_c) begin
                     gnt0      <= 1'b1;
                     last_srv  <= 1'b0;
                     pulse_cnt <= pulses_of(len0);
                  end else begin
                     gnt1      <= 1'b1;
                     last_srv  <= 1'b1;
                     pulse_cnt <= pulses_of(len1);
                  end
               end
            end
            GRANT: begin
               state     <= HIGH;
               signal    <= 1'b1;
               phase_cnt <= HIGH_LAST;
            end
            HIGH: begin
`ifdef PULSE_ABORT_EN
               if (abort) begin
                  state  <= DONE;
                  signal <= 1'b0;
                  done   <= 1'b1;
               end else
`endif
               if (phase_cnt == '0) begin
                  state     <= LOW;
                  signal    <= 1'b0;
                  phase_cnt <= LOW_LAST;
               end else begin
                  phase_cnt <= phase_cnt - CNT_W'(1);
               end
            end
            LOW: begin
`ifdef PULSE_ABORT_EN
               if (abort) begin
                  state  <= DONE;
                  signal <= 1'b0;
                  done   <= 1'b1;
               end else
`endif
               if (phase_cnt != '0) begin
                  phase_cnt <= phase_cnt - CNT_W'(1);
               end else if (pulse_cnt > CNT_W'(1)) begin
                  state     <= HIGH;
                  signal    <= 1'b1;
                  phase_cnt <= HIGH_LAST;
                  pulse_cnt <= pulse_cnt - CNT_W'(1);
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state     <= IDLE;
               busy      <= 1'b0;
               signal    <= 1'b0;
               phase_cnt <= '0;
               pulse_cnt <= '0;
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               signal <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_burst_arbiter.sv
// Self-checking bench for pulse_burst_arbiter: vector table, directed corner sequences
// and random traffic against a burst-sequence reference model.
module tb_pulse_burst_arbiter;

   localparam int unsigned HW = 3;
   localparam int unsigned LW = 3;

   logic       clock;
   logic       reset_n;
   logic       req0;
   logic [2:0] len0;
   logic       req1;
   logic [2:0] len1;
   logic       abort;
   logic       gnt0;
   logic       gnt1;
   logic       signal;
   logic       busy;
   logic       done;
   logic [4:0] outs;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: on each grant the whole output sequence of the burst is queued.
   logic [4:0] mq[$];
   logic       m_last = 1'b1;
   logic [4:0] exp_now;

   typedef struct {
      logic       req0;
      logic [2:0] len0;
      logic       req1;
      logic [2:0] len1;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl[$];

   pulse_burst_arbiter #(.HIGH_W(HW), .LOW_W(LW)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .req0   (req0),
      .len0   (len0),
      .req1   (req1),
      .len1   (len1),
`ifdef PULSE_ABORT_EN
      .abort  (abort),
`endif
      .gnt0   (gnt0),
      .gnt1   (gnt1),
      .signal (signal),
      .busy   (busy),
      .done   (done)
   );

   assign outs = {gnt0, gnt1, signal, busy, done};

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got {gnt0,gnt1,signal,busy,done}=%b, expected %b", name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_step();
      logic       win0;
      int         n;
      if (mq.size() == 0 && (req0 || req1)) begin
         win0   = req0 && (!req1 || m_last);
         n      = win0 ? ((len0 == 3'd0) ? 8 : int'(len0)) : ((len1 == 3'd0) ? 8 : int'(len1));
         m_last = !win0;
         mq.push_back(win0 ? 5'b10010 : 5'b01010);
         for (int p = 0; p < n; p++) begin
            for (int h = 0; h < int'(HW); h++) mq.push_back(5'b00110);
            for (int l = 0; l < int'(LW); l++) mq.push_back(5'b00010);
         end
         mq.push_back(5'b00011);
         mq.push_back(5'b00000);
      end
      exp_now = (mq.size() != 0) ? mq.pop_front() : 5'b00000;
   endtask

   // One clock: model advances with the DUT, outputs sampled 1 time unit after the edge.
   task automatic tick(input bit chk_model);
      @(posedge clock);
      model_step();
      #1;
      if (chk_model) check("model", outs, exp_now);
   endtask

   task automatic drain();
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (60) tick(1);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("reset_async", outs, 5'b00000);
      mq.delete();
      m_last = 1'b1;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      int pulses;
      int train;
      int cnt;
      bit seen;
      logic prev;

      reset_n = 1'b1;
      req0 = 1'b0; len0 = 3'd0; req1 = 1'b0; len1 = 3'd0; abort = 1'b0;

      // Single request, len0=2: grant, two 3/3 pulses, done, back to idle.
      tbl.push_back('{1'b1, 3'd2, 1'b0, 3'd0, 5'b10010});
      for (int p = 0; p < 2; p++) begin
         for (int h = 0; h < 3; h++) tbl.push_back('{1'b0, 3'd2, 1'b0, 3'd0, 5'b00110});
         for (int l = 0; l < 3; l++) tbl.push_back('{1'b0, 3'd2, 1'b0, 3'd0, 5'b00010});
      end
      tbl.push_back('{1'b0, 3'd2, 1'b0, 3'd0, 5'b00011});
      tbl.push_back('{1'b0, 3'd2, 1'b0, 3'd0, 5'b00000});

      #1 reset_n = 1'b0;
      #2 check("reset_state", outs, 5'b00000);
      #9 reset_n = 1'b1;

      cnt = 0;
      foreach (tbl[i]) begin
         req0 = tbl[i].req0; len0 = tbl[i].len0;
         req1 = tbl[i].req1; len1 = tbl[i].len1;
         tick(1);
         check($sformatf("vec%0d", i), outs, tbl[i].exp);
         if (busy) cnt++;
      end
      check_int("busy_cycles", cnt, 14);

      // Ties alternate: gnt0 first after reset, then gnt1, then gnt0.
      do_reset();
      req0 = 1'b1; len0 = 3'd1; req1 = 1'b1; len1 = 3'd1;
      tick(1);
      check("tie_first", outs, 5'b10010);
      cnt = 0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick(1);
         cnt++;
         if (gnt1) seen = 1;
      end
      check_int("tie_second_gnt1_at", seen ? cnt : -1, 9);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick(1);
         if (gnt0) seen = 1;
         if (gnt1) check("tie_third_not_gnt1", outs, 5'b10010);
      end
      check_int("tie_third_gnt0", int'(seen), 1);
      drain();

      // len1=0 means 8 pulses: 48-cycle train then done.
      req1 = 1'b1; len1 = 3'd0;
      tick(1);
      check("len8_grant", outs, 5'b01010);
      req1 = 1'b0;
      pulses = 0; train = 0; prev = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         tick(1);
         if (!done) train++;
         if (signal && !prev) pulses++;
         prev = signal;
      end
      check_int("len8_pulses", pulses, 8);
      check_int("len8_train", train, 48);
      check_int("len8_done", int'(done), 1);
      drain();

      // Inputs changed mid-burst are ignored; gnt1 waits for idle.
      req0 = 1'b1; len0 = 3'd1;
      tick(1);
      check("ign_grant", outs, 5'b10010);
      req0 = 1'b0;
      tick(1);
      req1 = 1'b1; len0 = 3'd5; len1 = 3'd2;
      pulses = 1; cnt = 1; seen = 0; prev = 1'b1;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick(1);
         cnt++;
         if (signal && !prev) pulses++;
         prev = signal;
         if (gnt1) seen = 1;
      end
      check_int("ign_pulses", pulses, 1);
      check_int("ign_gnt1_at", seen ? cnt : -1, 9);
      req1 = 1'b0;
      drain();

      // Reset during the second pulse aborts silently; a new req0 is granted after release.
      req0 = 1'b1; len0 = 3'd3;
      tick(1);
      req0 = 1'b0;
      repeat (7) tick(1);
      check("rst_mid_high", outs, 5'b00110);
      #2 reset_n = 1'b0;
      #1 check("rst_mid_async", outs, 5'b00000);
      mq.delete();
      m_last = 1'b1;
      tick(1);
      tick(1);
      check("rst_mid_nodone", outs, 5'b00000);
      reset_n = 1'b1;
      req0 = 1'b1; len0 = 3'd1;
      tick(1);
      check("rst_regrant", outs, 5'b10010);
      drain();

`ifdef PULSE_ABORT_EN
      // Abort in the first LOW phase jumps straight to done.
      req0 = 1'b1; len0 = 3'd4;
      tick(1);
      req0 = 1'b0;
      repeat (4) tick(1);
      check("abort_low", outs, 5'b00010);
      abort = 1'b1;
      tick(0);
      check("abort_done", outs, 5'b00011);
      abort = 1'b0;
      mq.delete();
      mq.push_back(5'b00000);
      tick(1);
      check("abort_idle", outs, 5'b00000);
      drain();
`endif

      // Random traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         req0 = ($urandom_range(0, 2) == 0);
         req1 = ($urandom_range(0, 2) == 0);
         len0 = 3'($urandom_range(0, 7));
         len1 = 3'($urandom_range(0, 7));
         tick(1);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pulse_burst_arbiter.md
PULSE_BURST_ARBITER -- requirements
Module: pulse_burst_arbiter

Interface
REQ-001 Parameter HIGH_W, default 3, sets the pulse high phase length in clock cycles; legal range 1..15.
REQ-002 Parameter LOW_W, default 3, sets the pulse low phase length in clock cycles; legal range 1..15.
REQ-003 Port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port req0, input, 1 bit: requester 0 burst request, level.
REQ-006 Port len0, input, 3 bits: requester 0 pulse count; 0 encodes 8 pulses.
REQ-007 Port req1, input, 1 bit: requester 1 burst request, level.
REQ-008 Port len1, input, 3 bits: requester 1 pulse count; 0 encodes 8 pulses.
REQ-009 Port gnt0, output, 1 bit: one-cycle grant strobe to requester 0.
REQ-010 Port gnt1, output, 1 bit: one-cycle grant strobe to requester 1.
REQ-011 Port signal, output, 1 bit: the shared pulse-train output.
REQ-012 Port busy, output, 1 bit: high in every state except IDLE.
REQ-013 Port done, output, 1 bit: one-cycle strobe marking the end of a burst.

Function
REQ-014 The block SHALL use the FSM states IDLE, GRANT, HIGH, LOW and DONE, and all outputs SHALL be registered.
REQ-015 In IDLE, if any req is sampled high at a rising edge, the next state SHALL be GRANT with exactly one gnt high, and the winner's len SHALL be latched.
REQ-016 When both requests are high, the grant SHALL go to the requester not served last (round-robin); the last-served pointer SHALL reset to 1, so req0 wins the first tie.
REQ-017 GRANT SHALL last 1 cycle and then go to HIGH; gnt0 and gnt1 SHALL be low in every state other than GRANT.
REQ-018 HIGH SHALL hold signal=1 for exactly HIGH_W cycles and then go to LOW.
REQ-019 LOW SHALL hold signal=0 for exactly LOW_W cycles; if pulses remain the next state SHALL be HIGH, otherwise DONE.
REQ-020 DONE SHALL last 1 cycle with done=1 and signal=0, and then go to IDLE.
REQ-021 Total burst length from the first HIGH cycle to the last LOW cycle SHALL be N*(HIGH_W+LOW_W) cycles, where N is the latched count (1..8).
REQ-022 Requests arriving outside IDLE SHALL be ignored until IDLE, and a requester SHALL drop req the cycle after its gnt; a req still high in IDLE SHALL be treated as a new request.
REQ-023 The phase counter SHALL be 4 bits and the pulse counter 4 bits; changes to len0 or len1 after GRANT SHALL have no effect on the running burst.

Reset
REQ-024 While reset_n=0, the block SHALL immediately and asynchronously force state=IDLE, signal=0, gnt0=0, gnt1=0, busy=0, done=0, all counters to 0 and pointer=1.
REQ-025 A reset asserted mid-burst SHALL abort the burst with no done strobe; operation SHALL resume at the first rising edge after reset_n returns high.

Configuration
REQ-026 With macro PULSE_ABORT_EN defined, the block SHALL add a 1-bit input port abort.
REQ-027 With PULSE_ABORT_EN defined, abort sampled high in HIGH or LOW SHALL force signal=0 and move to DONE on the next edge, and done SHALL still pulse.
REQ-028 With PULSE_ABORT_EN defined, abort SHALL be ignored in IDLE, GRANT and DONE.
REQ-029 Without PULSE_ABORT_EN, the abort port and its logic SHALL be absent, and every burst SHALL run to completion unless reset.

Verification
REQ-030 Scenario, single request: req0=1 with len0=2 -> gnt0 high for 1 cycle; signal pattern 1,1,1,0,0,0,1,1,1,0,0,0; then done for 1 cycle; busy high for 14 cycles.
REQ-031 Scenario, tie and round-robin: req0 and req1 high together from reset -> gnt0 first; after DONE with both still high -> gnt1; the next tie -> gnt0.
REQ-032 Scenario, len encoding: len1=0 with defaults -> exactly 8 pulses on signal, a 48-cycle train, then done.
REQ-033 Scenario, ignored inputs: req1 raised during the HIGH phase of a req0 burst with len0 changed to 5 -> the req0 burst keeps its latched count; gnt1 is issued only after DONE and IDLE.
REQ-034 Scenario, reset mid-burst: reset_n pulsed low during the second pulse -> signal, busy and gnt fall immediately; no done; a fresh req0 is granted after release.
REQ-035 Scenario, abort (PULSE_ABORT_EN defined): abort=1 in the first LOW of a len0=4 burst -> signal stays 0; done is high on the next cycle; IDLE follows.
